// File: rtl/nec_ir_tx.sv
// ============================================================================
// Module : nec_ir_tx
// NEC infrared transmitter: lead code, 32 pulse-distance bits (MSB first),
// stop mark; envelope, inverted envelope and 38 kHz carrier-modulated drive.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nec_ir_tx #(
    parameter int TICK_DIV      = 50,
    parameter int CARR_DIV      = 1316,
    parameter int LEAD_MARK_US  = 9000,
    parameter int LEAD_SPACE_US = 4500,
    parameter int BIT_MARK_US   = 560,
    parameter int ZERO_SPACE_US = 560,
    parameter int ONE_SPACE_US  = 1690
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_data,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_ir_tx,
    output logic        o_ir_txb,
    output logic        o_ir_led
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (CARR_DIV > 1) ? $clog2(CARR_DIV) : 1;
    localparam int PW = 17;

    localparam logic [TW-1:0] C_TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] C_CARR_LAST  = CW'(CARR_DIV - 1);
    localparam logic [CW-1:0] C_CARR_HALF  = CW'(CARR_DIV / 2);
    localparam logic [PW-1:0] C_LEAD_MARK  = PW'(LEAD_MARK_US);
    localparam logic [PW-1:0] C_LEAD_SPACE = PW'(LEAD_SPACE_US);
    localparam logic [PW-1:0] C_BIT_MARK   = PW'(BIT_MARK_US);
    localparam logic [PW-1:0] C_ZERO_SPACE = PW'(ZERO_SPACE_US);
    localparam logic [PW-1:0] C_ONE_SPACE  = PW'(ONE_SPACE_US);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LEAD_MARK  = 3'd1,
        S_LEAD_SPACE = 3'd2,
        S_BIT_MARK   = 3'd3,
        S_BIT_SPACE  = 3'd4,
        S_STOP_MARK  = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_tick_cnt;
    logic [PW-1:0] r_phase_cnt;
    logic [31:0]   r_shreg;
    logic [5:0]    r_bit_cnt;
    logic [CW-1:0] r_carr_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_ir_tx;
    logic          r_ir_txb;
    logic          r_ir_led;

    logic          w_tick;
    logic [PW-1:0] w_phase_len;
    logic          w_phase_end;
    logic          w_next_mark;
    logic          w_cur_mark;
    logic [CW-1:0] w_carr_inc;

    assign w_tick      = (r_tick_cnt == C_TICK_LAST);
    assign w_phase_end = w_tick && (r_phase_cnt == (w_phase_len - PW'(1)));
    assign w_next_mark = (w_next == S_LEAD_MARK) || (w_next == S_BIT_MARK) || (w_next == S_STOP_MARK);
    assign w_cur_mark  = (r_state == S_LEAD_MARK) || (r_state == S_BIT_MARK) || (r_state == S_STOP_MARK);
    assign w_carr_inc  = (r_carr_cnt == C_CARR_LAST) ? '0 : r_carr_cnt + CW'(1);

    always_comb begin
        w_phase_len = C_BIT_MARK;
        case (r_state)
            S_LEAD_MARK:  w_phase_len = C_LEAD_MARK;
            S_LEAD_SPACE: w_phase_len = C_LEAD_SPACE;
            S_BIT_SPACE:  w_phase_len = r_shreg[31] ? C_ONE_SPACE : C_ZERO_SPACE;
            default:      w_phase_len = C_BIT_MARK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (i_start)     w_next = S_LEAD_MARK;
            S_LEAD_MARK:  if (w_phase_end) w_next = S_LEAD_SPACE;
            S_LEAD_SPACE: if (w_phase_end) w_next = S_BIT_MARK;
            S_BIT_MARK:   if (w_phase_end) w_next = S_BIT_SPACE;
            S_BIT_SPACE:  if (w_phase_end) w_next = (r_bit_cnt == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
            S_STOP_MARK:  if (w_phase_end) w_next = S_DONE;
            S_DONE:       w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they switch on the same
    // edge as the state itself, with no combinational path from i_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt  <= '0;
            r_phase_cnt <= '0;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_carr_cnt  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ir_tx     <= 1'b0;
            r_ir_txb    <= 1'b1;
            r_ir_led    <= 1'b0;
        end else begin
            r_busy   <= (w_next != S_IDLE);
            r_done   <= (w_next == S_DONE);
            r_ir_tx  <= w_next_mark;
            r_ir_txb <= ~w_next_mark;

            if (!w_next_mark) begin
                r_carr_cnt <= '0;
                r_ir_led   <= 1'b0;
            end else if (!w_cur_mark) begin
                r_carr_cnt <= '0;
                r_ir_led   <= (C_CARR_HALF != '0);
            end else begin
                r_carr_cnt <= w_carr_inc;
                r_ir_led   <= (w_carr_inc < C_CARR_HALF);
            end

            if (r_state == S_IDLE) begin
                r_tick_cnt  <= '0;
                r_phase_cnt <= '0;
                if (i_start) begin
                    r_shreg   <= i_data;
                    r_bit_cnt <= '0;
                end
            end else begin
                r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
                if (w_next != r_state) begin
                    r_phase_cnt <= '0;
                end else if (w_tick) begin
                    r_phase_cnt <= r_phase_cnt + PW'(1);
                end
                if ((r_state == S_BIT_SPACE) && w_phase_end) begin
                    r_shreg   <= {r_shreg[30:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                end
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_ir_tx  = r_ir_tx;
    assign o_ir_txb = r_ir_txb;
    assign o_ir_led = r_ir_led;

endmodule

`default_nettype wire

// File: doc/nec_ir_tx.md
Name: nec_ir_tx

Overview:
NEC-protocol infrared transmitter, the transmit-side counterpart of the team's IR receiver.
- Accepts a 32-bit custom/data word through a start/busy/done handshake.
- Emits the word as a complete NEC frame: lead code, 32 pulse-distance bits (MSB first), stop mark.
- Provides an unmodulated envelope, an inverted envelope for direct loopback into the receiver's i_ir_rxb, and a carrier-modulated LED drive. Sits beside the receiver in top-level designs on the 50 MHz board clock.

Parameters:
TICK_DIV, 50, clk cycles per 1 us timing tick
CARR_DIV, 1316, clk cycles per carrier period (50 MHz / 1316 ≈ 38 kHz)
LEAD_MARK_US, 9000, lead mark length in us
LEAD_SPACE_US, 4500, lead space length in us
BIT_MARK_US, 560, mark length of every data bit and of the stop mark, in us
ZERO_SPACE_US, 560, space length after a '0' bit, in us
ONE_SPACE_US, 1690, space length after a '1' bit, in us

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  reset, asynchronous, active-low
i_data  input  32  frame word; bit 31 is transmitted first
i_start  input  1  transmit request, sampled only in IDLE
o_busy  output  1  high while a frame is in progress, i.e. in any state other than IDLE
o_done  output  1  one-cycle pulse at end of frame
o_ir_tx  output  1  envelope; 1 = mark (IR on)
o_ir_txb  output  1  ~o_ir_tx, polarity matches receiver input
o_ir_led  output  1  o_ir_tx AND 38 kHz carrier

Behaviour:
Reset (asynchronous, takes effect immediately, including mid-frame):
- State = IDLE.
- o_busy = 0, o_done = 0, o_ir_tx = 0, o_ir_txb = 1, o_ir_led = 0.
- Shift register, bit counter, phase counter and carrier counter all cleared.

States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, DONE.
- IDLE:
  - If i_start = 1 at a clock edge: latch i_data into the shift register, clear the bit counter and go to LEAD_MARK on that edge.
  - o_busy and o_ir_tx are registered and rise on the same edge.
- LEAD_MARK: o_ir_tx = 1 for exactly LEAD_MARK_US*TICK_DIV cycles, then LEAD_SPACE.
- LEAD_SPACE: o_ir_tx = 0 for LEAD_SPACE_US*TICK_DIV cycles, then BIT_MARK.
- BIT_MARK: o_ir_tx = 1 for BIT_MARK_US*TICK_DIV cycles, then BIT_SPACE.
- BIT_SPACE:
  - o_ir_tx = 0 for (shreg[31] ? ONE_SPACE_US : ZERO_SPACE_US)*TICK_DIV cycles.
  - On exit, shift the register left by 1 and increment the bit counter.
  - If 32 bits have been sent, go to STOP_MARK; otherwise go to BIT_MARK.
- STOP_MARK: o_ir_tx = 1 for BIT_MARK_US*TICK_DIV cycles, then DONE.
- DONE:
  - Lasts 1 cycle, with o_ir_tx = 0, o_done = 1 and o_busy = 1.
  - Then IDLE; a new i_start is accepted from the first IDLE cycle.

Timing and phase counter:
- Phase timing uses the 1 us tick divider, which restarts at 0 on every accepted start, so every phase length is exact and the frame is jitter-free relative to the start edge.
- Phase counter width ≥ 17 bits of ticks.
- The internal 1 us tick divider is a free-standing counter; no external NCO is required.

Carrier:
- The carrier counter restarts at 0 on every mark entry.
- Carrier is high for counts 0..CARR_DIV/2-1 and low for the rest of the period.
- o_ir_led = 0 throughout spaces, IDLE and DONE.

Handshake rules:
- i_start while busy is ignored and has no queueing effect.
- i_data is don't-care after the accepting edge; changes mid-frame do not alter the transmitted bits.
- A held-high i_start re-triggers back-to-back frames. Honouring the NEC 108 ms repeat interval is the caller's responsibility.

Frame length (default timings):
- 9000 + 4500 + Σ(560 + space) + 560 us.
- All zeros: 49,900 us. All ones: 86,060 us.

Outputs are registered, with no combinational path from i_start to any output.

Test Plan:
1. Defaults, i_data = 32'h00FF_A25D, single start pulse:
   - o_ir_tx high 450,000 cycles, then low 225,000 cycles.
   - Bit 31 ('0'): mark 28,000 / space 28,000 cycles.
   - Bit 23 ('1'): space 84,500 cycles.
   - Stop mark 28,000 cycles, then o_done pulses exactly once.
   - Loopback via o_ir_txb into the team's IR receiver yields o_data = 32'h00FF_A25D.
2. TICK_DIV = 1, all short timings = 2/1/1/1/3, i_data = 32'hFFFF_FFFF:
   - Total busy cycles = 2 + 1 + 32*(1+3) + 1 + 1(DONE) = 133.
   - With i_data = 0: 69 busy cycles.
3. Carrier check, defaults, during the lead mark:
   - o_ir_led toggles with period 1316 cycles at 658/658 duty.
   - o_ir_led = 0 through the entire lead space.
4. Handshake: pulse i_start again at 10,000 cycles into a frame and change i_data mid-frame:
   - No effect on the waveform.
   - o_done rises once.
   - i_start held high through DONE starts the second frame on the first IDLE cycle.
5. Assert rst_n = 0 during BIT_SPACE of bit 12:
   - Outputs go immediately to o_ir_tx = 0, o_ir_txb = 1, o_busy = 0, o_ir_led = 0.
   - After release, the next start sends a complete, correct frame from the lead mark.
6. i_start held low for 1 ms after reset: o_ir_tx stays 0, o_ir_txb stays 1, o_done never pulses.
